// File: rtl/sha512_chunk2.sv
// SHA-512 compression of two pre-padded 1024-bit blocks from the standard IV.
// One round per clock; the message schedule is generated in a 16-word sliding window.
module sha512_chunk2 (
   input  logic          clk,
   input  logic          reset,
   input  logic [1023:0] chunk0,
   input  logic [1023:0] chunk1,
   output logic          done,
   output logic [63:0]   oH0,
   output logic [63:0]   oH1,
   output logic [63:0]   oH2,
   output logic [63:0]   oH3,
   output logic [63:0]   oH4,
   output logic [63:0]   oH5,
   output logic [63:0]   oH6,
   output logic [63:0]   oH7
);

   typedef enum logic [2:0] {LOAD, RUN0, MID, RUN1, FIN, DONE} state_t;

   localparam logic [63:0] IV [8] = '{
      64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b, 64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
      64'h510e527fade682d1, 64'h9b05688c2b3e6c1f, 64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179};

   localparam logic [63:0] K [80] = '{
      64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
      64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
      64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
      64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
      64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
      64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
      64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
      64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
      64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
      64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
      64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
      64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
      64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
      64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
      64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
      64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
      64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
      64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
      64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
      64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817};

   state_t        state;
   logic [6:0]    round;
   logic [63:0]   hreg [8];
   logic [63:0]   v    [8];
   logic [63:0]   w    [16];
   logic [1023:0] hold;
   logic [63:0]   t1, t2, w_next;

   function automatic logic [63:0] rotr(input logic [63:0] x, input int unsigned n);
      return (x >> n) | (x << (64 - n));
   endfunction

   always_comb begin
      t1 = '0;
      t2 = '0;
      w_next = '0;
      t1 = v[7] + (rotr(v[4], 14) ^ rotr(v[4], 18) ^ rotr(v[4], 41))
         + ((v[4] & v[5]) ^ (~v[4] & v[6])) + K[round] + w[0];
      t2 = (rotr(v[0], 28) ^ rotr(v[0], 34) ^ rotr(v[0], 39))
         + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      // w[0] is W[t]; this yields W[t+16] to enter at the top of the window
      w_next = (rotr(w[14], 19) ^ rotr(w[14], 61) ^ (w[14] >> 6)) + w[9]
             + (rotr(w[1], 1) ^ rotr(w[1], 8) ^ (w[1] >> 7)) + w[0];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= LOAD;
         round <= '0;
         done  <= 1'b0;
         hold  <= chunk1;
         for (int unsigned i = 0; i < 8; i++) begin
            hreg[i] <= IV[i];
            v[i]    <= IV[i];
         end
         for (int unsigned i = 0; i < 16; i++) w[i] <= chunk0[1023 - 64*i -: 64];
      end else begin
         case (state)
            // LOAD already holds the chunk0 window, so the first released edge is round 0
            LOAD, RUN0, RUN1: begin
               v[7] <= v[6];
               v[6] <= v[5];
               v[5] <= v[4];
               v[4] <= v[3] + t1;
               v[3] <= v[2];
               v[2] <= v[1];
               v[1] <= v[0];
               v[0] <= t1 + t2;
               for (int unsigned i = 0; i < 15; i++) w[i] <= w[i+1];
               w[15] <= w_next;
               if (round == 7'd79) begin
                  round <= '0;
                  state <= (state == RUN1) ? FIN : MID;
               end else begin
                  round <= round + 7'd1;
                  if (state == LOAD) state <= RUN0;
               end
            end
            MID: begin
               for (int unsigned i = 0; i < 8; i++) begin
                  hreg[i] <= hreg[i] + v[i];
                  v[i]    <= hreg[i] + v[i];
               end
               for (int unsigned i = 0; i < 16; i++) w[i] <= hold[1023 - 64*i -: 64];
               round <= '0;
               state <= RUN1;
            end
            FIN: begin
               for (int unsigned i = 0; i < 8; i++) hreg[i] <= hreg[i] + v[i];
               done  <= 1'b1;
               state <= DONE;
            end
            DONE: ;
            default: state <= LOAD;
         endcase
      end
   end

   assign oH0 = hreg[0];
   assign oH1 = hreg[1];
   assign oH2 = hreg[2];
   assign oH3 = hreg[3];
   assign oH4 = hreg[4];
   assign oH5 = hreg[5];
   assign oH6 = hreg[6];
   assign oH7 = hreg[7];

endmodule

// File: tb/tb_sha512_chunk2.sv
// Self-checking bench for sha512_chunk2: a behavioural SHA-512 model fills a scoreboard
// queue at stimulus time; digests are popped and compared when done rises.
module tb_sha512_chunk2;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [1023:0] chunk0 = '0;
   logic [1023:0] chunk1 = '0;
   logic          done;
   logic [63:0]   oH0, oH1, oH2, oH3, oH4, oH5, oH6, oH7;
   logic [511:0]  dig;

   int n_assert = 0;
   int n_fail = 0;
   int edge_n = 0;
   logic [511:0] expq [$];

   localparam logic [511:0] IV = {
      64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b, 64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
      64'h510e527fade682d1, 64'h9b05688c2b3e6c1f, 64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179};

   localparam logic [511:0] FIPS_DIGEST = {
      64'h8e959b75dae313da, 64'h8cf4f72814fc143f, 64'h8f7779c6eb9f7fa1, 64'h7299aeadb6889018,
      64'h501d289e4900f7e4, 64'h331b99dec4b5433a, 64'hc7d329eeb6dd2654, 64'h5e96e55b874be909};

   localparam logic [63:0] KT [80] = '{
      64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
      64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
      64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
      64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
      64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
      64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
      64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
      64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
      64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
      64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
      64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
      64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
      64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
      64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
      64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
      64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
      64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
      64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
      64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
      64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817};

   sha512_chunk2 dut (
      .clk(clk), .reset(reset), .chunk0(chunk0), .chunk1(chunk1), .done(done),
      .oH0(oH0), .oH1(oH1), .oH2(oH2), .oH3(oH3),
      .oH4(oH4), .oH5(oH5), .oH6(oH6), .oH7(oH7));

   assign dig = {oH0, oH1, oH2, oH3, oH4, oH5, oH6, oH7};

   always #5 clk = ~clk;

   function automatic logic [63:0] ror(input logic [63:0] x, input int n);
      return (x >> n) | (x << (64 - n));
   endfunction

   function automatic logic [511:0] compress(input logic [511:0] hin, input logic [1023:0] blk);
      logic [63:0] wm [80];
      logic [63:0] hh [8];
      logic [63:0] a, b, c, d, e, f, g, h, s0, s1, x1, x2;
      logic [511:0] hout;
      for (int i = 0; i < 8; i++) hh[i] = hin[511 - 64*i -: 64];
      for (int t = 0; t < 16; t++) wm[t] = blk[1023 - 64*t -: 64];
      for (int t = 16; t < 80; t++) begin
         s0 = ror(wm[t-15], 1) ^ ror(wm[t-15], 8) ^ (wm[t-15] >> 7);
         s1 = ror(wm[t-2], 19) ^ ror(wm[t-2], 61) ^ (wm[t-2] >> 6);
         wm[t] = s1 + wm[t-7] + s0 + wm[t-16];
      end
      a = hh[0]; b = hh[1]; c = hh[2]; d = hh[3];
      e = hh[4]; f = hh[5]; g = hh[6]; h = hh[7];
      for (int t = 0; t < 80; t++) begin
         x1 = h + (ror(e, 14) ^ ror(e, 18) ^ ror(e, 41)) + ((e & f) ^ (~e & g)) + KT[t] + wm[t];
         x2 = (ror(a, 28) ^ ror(a, 34) ^ ror(a, 39)) + ((a & b) ^ (a & c) ^ (b & c));
         h = g; g = f; f = e; e = d + x1;
         d = c; c = b; b = a; a = x1 + x2;
      end
      hout = {hh[0] + a, hh[1] + b, hh[2] + c, hh[3] + d,
              hh[4] + e, hh[5] + f, hh[6] + g, hh[7] + h};
      return hout;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic check_digest(input string tag, input logic [511:0] expv);
      for (int i = 0; i < 8; i++)
         check($sformatf("%s_H%0d", tag, i), dig[511 - 64*i -: 64], expv[511 - 64*i -: 64]);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      edge_n++;
   endtask

   task automatic start(input logic [1023:0] c0, input logic [1023:0] c1);
      @(negedge clk);
      reset = 1'b1;
      chunk0 = c0;
      chunk1 = c1;
      expq.push_back(compress(compress(IV, c0), c1));
      @(negedge clk);
      reset = 1'b0;
      edge_n = 0;
   endtask

   task automatic step_to(input int target);
      while (edge_n < target) tick();
   endtask

   task automatic finish_run(input string tag);
      logic [511:0] expv;
      while (done !== 1'b1 && edge_n < 400) tick();
      check({tag, "_done"}, {63'b0, done}, 64'd1);
      check({tag, "_latency"}, 64'(edge_n), 64'd162);
      expv = (expq.size() > 0) ? expq.pop_front() : '0;
      check_digest(tag, expv);
   endtask

   initial begin
      logic [1023:0] fips0, fips1, r0, r1;
      logic [511:0]  held;

      fips0 = '0;
      for (int j = 0; j < 112; j++) fips0[1023 - 8*j -: 8] = 8'(8'h61 + j/8 + j%8);
      fips0[1023 - 8*112 -: 8] = 8'h80;
      fips1 = 1024'h380;

      // reset held several cycles
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_done", {63'b0, done}, 64'd0);
      check_digest("rst", IV);

      // FIPS two-block vector, with mid-run and edge-161 checks
      start(fips0, fips1);
      step_to(100);
      check_digest("fips_mid", compress(IV, fips0));
      step_to(161);
      check("fips_161_done", {63'b0, done}, 64'd0);
      finish_run("fips");
      check_digest("fips_const", FIPS_DIGEST);

      // sparse words
      start(1024'h1 << 960, 1024'h2 << 960);
      finish_run("sparse");

      // reset pulse at edge 120 restarts the whole sequence
      start(fips0, fips1);
      step_to(120);
      check("abort_pre_done", {63'b0, done}, 64'd0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      edge_n = 0;
      finish_run("abort");

      // inputs change after latching; must be ignored, then DONE holds
      r0 = {32{$urandom()}};
      r1 = {32{$urandom()}};
      start(r0, r1);
      step_to(5);
      @(negedge clk);
      chunk0 = ~r0;
      chunk1 = r0 ^ r1 ^ 1024'h5a5a;
      finish_run("iso");
      held = compress(compress(IV, r0), r1);
      for (int c = 0; c < 50; c++) begin
         tick();
         check("hold_done", {63'b0, done}, 64'd1);
         check("hold_H0", oH0, held[511:448]);
         check("hold_H7", oH7, held[63:0]);
      end

      check("scoreboard_empty", 64'(expq.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
